// File: rtl/led_scan_sequencer.sv
// led_scan_sequencer
//
// Step timing and scan position generator for the LED chaser display.
// A programmable prescaler produces one tick every BASE_PERIOD<<speed
// cycles. A STOP/RUN/DWELL state machine advances the lit position on each
// tick, in either bounce mode (0..N-1..0) or wrap mode (0..N-1, 0, ...).
// In bounce mode it can optionally hold each endpoint for DWELL extra ticks.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   run         1 = scan, 0 = pause (position retained)
//   mode        0 = bounce, 1 = wrap
//   speed       step period = BASE_PERIOD << speed cycles
//   pos         current lit LED index
//   dir         0 = ascending, 1 = descending
//   led_n       active-low one-hot; bit (NUM_LEDS-1-pos) is 0
//   step_pulse  high for the one cycle after each edge that changed pos
//   busy        1 whenever the state machine is not in STOP
//   state       state machine state (0 = STOP, 1 = RUN, 2 = DWELL)
//
// All outputs are registers. led_n is loaded together with pos, from the
// same value, so the pattern always matches the index.

module led_scan_sequencer #(
    parameter int NUM_LEDS    = 8,
    parameter int BASE_PERIOD = 25000000,
    parameter int CNT_W       = 28,
    parameter int DWELL       = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        run,
    input  logic                        mode,
    input  logic [1:0]                  speed,
    output logic [$clog2(NUM_LEDS)-1:0] pos,
    output logic                        dir,
    output logic [NUM_LEDS-1:0]         led_n,
    output logic                        step_pulse,
    output logic                        busy,
    output logic [1:0]                  state
);

    localparam int               PW   = $clog2(NUM_LEDS);
    localparam int               PERW = CNT_W + 3;
    localparam logic [PW-1:0]    LAST = PW'(NUM_LEDS - 1);
    localparam logic [3:0]       DW   = 4'(DWELL);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DWELL = 2'd2
    } state_t;

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       dwell_cnt;

    logic [PERW-1:0]  period_m1;
    logic             tick;
    logic             at_end;
    logic [PW-1:0]    wrap_pos;
    logic [PW-1:0]    bounce_pos;
    logic [PW-1:0]    step_pos;

    assign state = st;

    // Compare in CNT_W+3 bits so BASE_PERIOD<<3 cannot overflow. Using >=
    // means lowering speed mid-count fires the tick on the next cycle
    // instead of waiting for the counter to wrap.
    assign period_m1 = (PERW'(BASE_PERIOD) << speed) - PERW'(1);
    assign tick      = ({3'b000, cnt} >= period_m1);

    // Endpoint in the current travel direction. A stale dir (left over
    // from wrap mode) is corrected here before any step, so pos never
    // leaves 0..N-1.
    assign at_end     = (!dir && pos == LAST) || (dir && pos == '0);
    assign wrap_pos   = (pos == LAST) ? '0 : pos + PW'(1);
    // At an endpoint the direction flips before the step.
    assign bounce_pos = (dir ^ at_end) ? pos - PW'(1) : pos + PW'(1);
    // DWELL is only entered at an endpoint and pos/dir are frozen there,
    // so bounce_pos is also the correct exit step from DWELL.
    assign step_pos   = mode ? wrap_pos : bounce_pos;

    function automatic logic [NUM_LEDS-1:0] led_decode(input logic [PW-1:0] p);
        logic [NUM_LEDS-1:0] one_hot;
        one_hot            = '0;
        one_hot[LAST - p]  = 1'b1;
        return ~one_hot;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= ST_STOP;
            pos        <= '0;
            dir        <= 1'b0;
            cnt        <= '0;
            dwell_cnt  <= '0;
            step_pulse <= 1'b0;
            busy       <= 1'b0;
            led_n      <= led_decode('0);
        end else begin
            step_pulse <= 1'b0;
            case (st)
                ST_STOP: begin
                    cnt <= '0;
                    if (run) begin
                        st   <= ST_RUN;
                        busy <= 1'b1;
                    end
                end

                ST_RUN: begin
                    if (!run) begin
                        // Pause wins over a tick in the same cycle.
                        st   <= ST_STOP;
                        busy <= 1'b0;
                        cnt  <= '0;
                    end else if (!tick) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        cnt <= '0;
                        if (!mode && at_end && DW != 4'd0) begin
                            st        <= ST_DWELL;
                            dwell_cnt <= 4'd1;
                        end else begin
                            pos        <= step_pos;
                            led_n      <= led_decode(step_pos);
                            step_pulse <= 1'b1;
                            dir        <= mode ? 1'b0 : (dir ^ at_end);
                        end
                    end
                end

                ST_DWELL: begin
                    if (!run) begin
                        // dwell_cnt is kept across the pause.
                        st   <= ST_STOP;
                        busy <= 1'b0;
                        cnt  <= '0;
                    end else if (!tick) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        cnt <= '0;
                        if (mode || dwell_cnt >= DW) begin
                            // Hold complete, or wrap mode requested: leave
                            // now with the step the current mode dictates.
                            st         <= ST_RUN;
                            pos        <= step_pos;
                            led_n      <= led_decode(step_pos);
                            step_pulse <= 1'b1;
                            dir        <= mode ? 1'b0 : ~dir;
                            dwell_cnt  <= '0;
                        end else begin
                            dwell_cnt <= dwell_cnt + 4'd1;
                        end
                    end
                end

                default: begin
                    st   <= ST_STOP;
                    busy <= 1'b0;
                    cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/led_scan_sequencer.md
Name: led_scan_sequencer

Overview:
Upstream stage of the LED chaser. It generates the step timing and scan position for the 8-LED "knight rider" display and drives the active-low LED pattern directly.
- Contains a programmable prescaler and a RUN/DWELL/STOP state machine.
- Supports bounce and wrap scan modes with optional endpoint dwell.
- Replaces the free-running divider and the unbounded phase decode with one deterministic, resettable sequencer.

Parameters:
NUM_LEDS, 8, number of LEDs scanned; legal range 2..16.
BASE_PERIOD, 25000000, prescaler period in clk cycles at speed=0; must be >=2.
CNT_W, 28, prescaler width; must hold (BASE_PERIOD<<3)-1.
DWELL, 0, extra ticks held at each endpoint in bounce mode; legal range 0..15.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
run  in  1  1 = scan, 0 = pause (position retained)
mode  in  1  0 = bounce, 1 = wrap (0..N-1, 0, ...)
speed  in  2  step period = BASE_PERIOD<<speed cycles
pos  out  clog2(NUM_LEDS)  current lit LED index
dir  out  1  0 = ascending, 1 = descending
led_n  out  NUM_LEDS  active-low one-hot; bit (NUM_LEDS-1-pos) = 0, all others 1
step_pulse  out  1  one-cycle strobe after each pos change
busy  out  1  1 when state != STOP

Behaviour:
Clock and reset:
- Reset is sampled on the clk rising edge only.
- Reset values: state=STOP, pos=0, dir=0, prescaler=0, dwell_cnt=0, step_pulse=0, busy=0, led_n=0111_1111 (N=8).
- Reset overrides all other inputs in the same cycle. A reset arriving mid-scan or mid-dwell returns everything to these values.

Outputs:
- All outputs are registered.
- led_n is decoded from the registered pos, so it never shows an X or all-ones pattern.

Prescaler:
- Counts only in RUN and DWELL; it is forced to 0 in STOP.
- tick = (cnt >= (BASE_PERIOD<<speed)-1). On tick, cnt goes to 0.
- Using >= keeps timing safe when speed is lowered mid-count: the tick fires on the next cycle.
- The compare is done in CNT_W+3 bits, so there is no overflow.

States:
- STOP:
  - If run=1, go to RUN on the next edge.
  - pos, dir and dwell_cnt are held.
- RUN:
  - If run=0, go to STOP on the next edge. This takes priority over a tick in the same cycle.
  - On tick in wrap mode: pos = (pos==N-1) ? 0 : pos+1; dir=0.
  - On tick in bounce mode, not at an endpoint in the travel direction: pos moves one step in direction dir.
  - On tick in bounce mode, at an endpoint (dir=0 and pos=N-1, or dir=1 and pos=0):
    - If DWELL=0: flip dir and step immediately (7 then 6).
    - Otherwise: go to DWELL with dwell_cnt=1. pos is unchanged and there is no step_pulse.
- DWELL:
  - run=0: go to STOP; dwell_cnt is retained.
  - On tick with dwell_cnt<DWELL: increment dwell_cnt.
  - On tick with dwell_cnt==DWELL: flip dir, step pos, clear dwell_cnt, return to RUN.
  - If mode is 1 on a tick: leave immediately with wrap behaviour (pos N-1 goes to 0, dir=0, dwell_cnt=0).

Other rules:
- A mode change takes effect at the next tick.
- In bounce mode a stale dir is corrected at an endpoint before any step, so pos never exceeds N-1 or underflows 0.
- step_pulse is 1 for exactly the cycle after any edge on which pos changed, else 0.
- Timing: the first pos change occurs BASE_PERIOD<<speed edges after the edge that enters RUN. Steady-state step period is exactly BASE_PERIOD<<speed cycles.

Test Plan:
- Bounce walk (BASE_PERIOD=4, speed=0, N=8, DWELL=0, mode=0): reset, then hold run=1.
  - Required: pos 0,1,...,7,6,...,0,1 with each step exactly 4 cycles apart.
  - Required: led_n at pos 7 = 1111_1110; step_pulse count = 14 per full period.
- Wrap and speed: mode=1, speed=2.
  - Required: pos 0..7,0 with steps 16 cycles apart; dir stays 0.
  - Switch speed 2→0 while cnt=10: the next tick fires on the next cycle, then steps are 4 cycles apart.
- Dwell (DWELL=2):
  - Required: pos holds 7 for 3 step periods (12 cycles), then goes to 6 with dir=1; no step_pulse during the hold.
  - Same hold behaviour at pos 0.
- Pause: drop run at pos=3, dir=1, hold 50 cycles, then raise run.
  - Required: busy=0 and pos=3 during the pause; the next step is to pos 2 exactly 4 cycles after re-entering RUN.
- Reset mid-dwell: assert reset while in DWELL at pos=7.
  - Required next cycle: pos=0, dir=0, busy=0, led_n=0111_1111, step_pulse=0.
- Mode flip in DWELL (DWELL=3, at pos 7): set mode=1.
  - Required at the next tick: pos=0, dir=0, state RUN.
